// File: rtl/async_fifo_lvl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : async_fifo_lvl
// Description : Dual-clock FIFO with Gray-coded pointers crossing domains
//               through SYNC_STAGES-deep synchronisers. Provides per-domain
//               fill levels, almost-full / almost-empty flags, sticky
//               overflow / underflow flags and a read port with rvalid.
//               Optional macro FIFO_FWFT_EN selects first-word fall-through;
//               when undefined, reads are registered (standard mode).
// Ports       : wclk/wrst_n      write clock, async active-low write reset
//               winc/wdata       write request and data
//               wfull/wafull     full / almost-full (wclk domain)
//               wlevel           occupancy seen by the writer
//               woverflow        sticky, set by winc while wfull
//               rclk/rrst_n      read clock, async active-low read reset
//               rinc             read request
//               rdata/rvalid     read data and valid
//               rempty/raempty   empty / almost-empty (rclk domain)
//               rlevel           occupancy seen by the reader
//               runderflow       sticky, set by rinc while rempty
// Revision    : 1.0  initial release
// ============================================================================
module async_fifo_lvl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 12,
    parameter int AEMPTY_TH   = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  wafull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow,
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  runderflow
);

    localparam int                c_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_AFULL  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AEMPTY = AEMPTY_TH[ADDR_WIDTH:0];

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0]                  r_wbin;
    logic [ADDR_WIDTH:0]                  r_wptr;
    logic                                 r_wfull;
    logic                                 r_wafull;
    logic [ADDR_WIDTH:0]                  r_wlevel;
    logic                                 r_woverflow;
    logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] r_wq_rptr;   // [0] newest stage

    logic                w_wpush;
    logic [ADDR_WIDTH:0] w_wbin_next;
    logic [ADDR_WIDTH:0] w_wgray_next;
    logic [ADDR_WIDTH:0] w_wq2_rptr;
    logic [ADDR_WIDTH:0] w_rbin_sync;
    logic [ADDR_WIDTH:0] w_wlevel_next;
    logic                w_wfull_next;

    assign w_wpush       = winc & ~r_wfull;
    assign w_wbin_next   = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wpush};
    assign w_wgray_next  = (w_wbin_next >> 1) ^ w_wbin_next;
    assign w_wq2_rptr    = r_wq_rptr[SYNC_STAGES-1];
    assign w_rbin_sync   = gray2bin(w_wq2_rptr);
    // Modulo-2**(A+1) subtraction; the stale read pointer makes this
    // an over-estimate, which is the safe direction for the writer.
    assign w_wlevel_next = w_wbin_next - w_rbin_sync;
    // Full when the two Gray MSBs are inverted and the rest match.
    assign w_wfull_next  = (w_wgray_next ==
                            {~w_wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], w_wq2_rptr[ADDR_WIDTH-2:0]});

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wq_rptr <= '0;
        end else begin
            r_wq_rptr <= {r_wq_rptr[SYNC_STAGES-2:0], r_rptr};
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin      <= '0;
            r_wptr      <= '0;
            r_wfull     <= 1'b0;
            r_wafull    <= 1'b0;
            r_wlevel    <= '0;
            r_woverflow <= 1'b0;
        end else begin
            r_wbin      <= w_wbin_next;
            r_wptr      <= w_wgray_next;
            r_wfull     <= w_wfull_next;
            r_wafull    <= (w_wlevel_next >= c_AFULL);
            r_wlevel    <= w_wlevel_next;
            r_woverflow <= r_woverflow | (winc & r_wfull);
        end
    end

    always_ff @(posedge wclk) begin
        if (w_wpush) begin
            r_mem[r_wbin[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    assign wfull     = r_wfull;
    assign wafull    = r_wafull;
    assign wlevel    = r_wlevel;
    assign woverflow = r_woverflow;

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0]                  r_rbin;
    logic [ADDR_WIDTH:0]                  r_rptr;
    logic                                 r_rempty;
    logic                                 r_raempty;
    logic [ADDR_WIDTH:0]                  r_rlevel;
    logic                                 r_runderflow;
    logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] r_rq_wptr;   // [0] newest stage

    logic                w_rpop;
    logic [ADDR_WIDTH:0] w_rbin_next;
    logic [ADDR_WIDTH:0] w_rgray_next;
    logic [ADDR_WIDTH:0] w_wbin_sync;
    logic [ADDR_WIDTH:0] w_rlevel_next;

    assign w_rpop        = rinc & ~r_rempty;
    assign w_rbin_next   = r_rbin + {{ADDR_WIDTH{1'b0}}, w_rpop};
    assign w_rgray_next  = (w_rbin_next >> 1) ^ w_rbin_next;
    assign w_wbin_sync   = gray2bin(r_rq_wptr[SYNC_STAGES-1]);
    // Stale write pointer makes this an under-estimate: safe for the reader.
    assign w_rlevel_next = w_wbin_sync - w_rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rq_wptr <= '0;
        end else begin
            r_rq_wptr <= {r_rq_wptr[SYNC_STAGES-2:0], r_wptr};
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin       <= '0;
            r_rptr       <= '0;
            r_rempty     <= 1'b1;
            r_raempty    <= 1'b1;
            r_rlevel     <= '0;
            r_runderflow <= 1'b0;
        end else begin
            r_rbin       <= w_rbin_next;
            r_rptr       <= w_rgray_next;
            r_rempty     <= (w_rgray_next == r_rq_wptr[SYNC_STAGES-1]);
            r_raempty    <= (w_rlevel_next <= c_AEMPTY);
            r_rlevel     <= w_rlevel_next;
            r_runderflow <= r_runderflow | (rinc & r_rempty);
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is visible as soon as the FIFO is non-empty; the write
    // that filled it completed before the pointer crossed over.
    assign rdata  = r_rempty ? '0 : r_mem[r_rbin[ADDR_WIDTH-1:0]];
    assign rvalid = ~r_rempty;
`else
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rpop;
            if (w_rpop) begin
                r_rdata <= r_mem[r_rbin[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
`endif

    assign rempty     = r_rempty;
    assign raempty    = r_raempty;
    assign rlevel     = r_rlevel;
    assign runderflow = r_runderflow;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_lvl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_lvl
// Description : Self-checking bench for async_fifo_lvl. Table-driven fill,
//               hand sequences for overflow/underflow/latency, and a
//               randomized dual-clock run against a queue reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_async_fifo_lvl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int N_RND = 10000;

    logic          wclk = 1'b0;
    logic          rclk = 1'b0;
    logic          wrst_n, rrst_n, winc, rinc;
    logic [DW-1:0] wdata;

    logic          wfull, wafull, woverflow, rvalid, rempty, raempty, runderflow;
    logic [AW:0]   wlevel, rlevel;
    logic [DW-1:0] rdata;

    logic          wfull3, wafull3, woverflow3, rvalid3, rempty3, raempty3, runderflow3;
    logic [AW:0]   wlevel3, rlevel3;
    logic [DW-1:0] rdata3;

    int total = 0;
    int bad   = 0;

    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] q[$];

    always #5 wclk = ~wclk;                      // 100 MHz
    initial begin #8; forever #10 rclk = ~rclk; end  // 50 MHz, offset phase

    async_fifo_lvl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
                     .AFULL_TH(12), .AEMPTY_TH(2)) u_dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .woverflow(woverflow),
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rdata(rdata), .rvalid(rvalid),
        .rempty(rempty), .raempty(raempty), .rlevel(rlevel), .runderflow(runderflow)
    );

    async_fifo_lvl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(3),
                     .AFULL_TH(12), .AEMPTY_TH(2)) u_dut3 (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull3), .wafull(wafull3), .wlevel(wlevel3), .woverflow(woverflow3),
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rdata(rdata3), .rvalid(rvalid3),
        .rempty(rempty3), .raempty(raempty3), .rlevel(rlevel3), .runderflow(runderflow3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        winc = 1'b0; rinc = 1'b0; wdata = '0;
        wrst_n = 1'b0; rrst_n = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        chk("rst_wfull", wfull, 0);
        chk("rst_wafull", wafull, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_woverflow", woverflow, 0);
        chk("rst_rempty", rempty, 1);
        chk("rst_raempty", raempty, 1);
        chk("rst_rlevel", rlevel, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_runderflow", runderflow, 0);
        @(negedge wclk);
        wrst_n = 1'b1; rrst_n = 1'b1;
        @(posedge wclk); #1;
    endtask

    // Wait (bounded) for data, then pop one word and check it.
    task automatic rd_check(input logic [DW-1:0] exp, input string name);
        int n = 0;
        while (rempty && n < 64) begin
            @(posedge rclk); #1; n++;
        end
        chk({name, "_wait"}, rempty, 0);
        if (rempty) return;
`ifdef FIFO_FWFT_EN
        chk({name, "_fwft_data"}, rdata, exp);
        chk({name, "_fwft_valid"}, rvalid, 1);
`endif
        rinc = 1'b1;
        @(posedge rclk); #1;
        rinc = 1'b0;
`ifndef FIFO_FWFT_EN
        chk({name, "_rvalid"}, rvalid, 1);
        chk({name, "_rdata"}, rdata, exp);
`endif
    endtask

    task automatic writer_proc();
        logic          w, wpend;
        logic [DW-1:0] d;
        int            occ, n_wr, cyc;
        wpend = 1'b0; n_wr = 0;
        for (cyc = 0; cyc < 80000 && n_wr < N_RND; cyc++) begin
            @(posedge wclk);
            if (wpend) wr_cnt++;
            #1;
            occ = wr_cnt - rd_cnt;
            chk("rnd_wfull_safe", (!wfull && occ >= DEPTH), 0);
            chk("rnd_wlevel_safe", (int'(wlevel) < occ), 0);
            w = ($urandom_range(0, 1) == 1);
            d = $urandom;
            wpend = w && !wfull;
            winc  = w;
            wdata = d;
            if (wpend) begin
                q.push_back(d);
                n_wr++;
            end
        end
        chk("rnd_wr_done", n_wr, N_RND);
        @(posedge wclk);
        if (wpend) wr_cnt++;
        #1;
        winc = 1'b0;
    endtask

    task automatic reader_proc();
        logic          r, pend;
        logic [DW-1:0] exp;
        int            occ, n_rd, cyc;
        pend = 1'b0; n_rd = 0; exp = '0;
        for (cyc = 0; cyc < 40000 && n_rd < N_RND; cyc++) begin
            @(posedge rclk);
            if (pend) rd_cnt++;
            #1;
`ifndef FIFO_FWFT_EN
            chk("rnd_rvalid", rvalid, pend);
            if (pend) chk("rnd_rdata", rdata, exp);
`endif
            occ = wr_cnt - rd_cnt;
            chk("rnd_rempty_safe", (!rempty && occ <= 0), 0);
            chk("rnd_rlevel_safe", (int'(rlevel) > occ), 0);
            r    = ($urandom_range(0, 9) < 7);
            pend = r && !rempty;
            if (!rempty) begin
                chk("rnd_model_nonempty", (q.size() == 0), 0);
                if (q.size() > 0) begin
`ifdef FIFO_FWFT_EN
                    chk("rnd_fwft_data", rdata, q[0]);
                    chk("rnd_fwft_valid", rvalid, 1);
`endif
                    if (pend) exp = q.pop_front();
                end
                if (pend) n_rd++;
            end
            rinc = r;
        end
        chk("rnd_rd_done", n_rd, N_RND);
        @(posedge rclk);
        if (pend) rd_cnt++;
        #1;
        rinc = 1'b0;
`ifndef FIFO_FWFT_EN
        chk("rnd_rvalid_last", rvalid, pend);
        if (pend) chk("rnd_rdata_last", rdata, exp);
`endif
    endtask

    typedef struct {
        logic          winc;
        logic [DW-1:0] wdata;
        logic          exp_wfull;
        logic          exp_wafull;
        logic [AW:0]   exp_wlevel;
        logic          exp_wovf;
    } vec_t;

    vec_t tv [17];

    initial begin
        int lat2, lat3, n;

        // Fill table: writes 1..16, then a rejected write while full.
        for (int i = 0; i < 16; i++) begin
            tv[i].winc       = 1'b1;
            tv[i].wdata      = DW'(i + 1);
            tv[i].exp_wfull  = ((i + 1) == DEPTH);
            tv[i].exp_wafull = ((i + 1) >= 12);
            tv[i].exp_wlevel = (AW+1)'(i + 1);
            tv[i].exp_wovf   = 1'b0;
        end
        tv[16].winc       = 1'b1;
        tv[16].wdata      = 32'hDEAD;
        tv[16].exp_wfull  = 1'b1;
        tv[16].exp_wafull = 1'b1;
        tv[16].exp_wlevel = (AW+1)'(DEPTH);
        tv[16].exp_wovf   = 1'b1;

        // ---- Empty-to-non-empty latency for 2 and 3 sync stages, 0xA5 ----
        do_reset();
        winc = 1'b1; wdata = 32'hA5;
        @(posedge wclk); #1;
        winc = 1'b0;
        lat2 = 0; lat3 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge rclk); #1;
            if (lat2 == 0 && !rempty) begin
                lat2 = k;
                chk("lat_rlevel", rlevel, 1);
                chk("lat_raempty", raempty, 1);
            end
            if (lat3 == 0 && !rempty3) lat3 = k;
        end
        chk("latency_sync2", lat2, 3);
        chk("latency_sync3", lat3, 4);
        rd_check(32'hA5, "a5");
        @(posedge rclk); #1;
        chk("a5_rvalid_one_cycle", rvalid, 0);
`ifndef FIFO_FWFT_EN
        chk("a5_rdata_hold", rdata, 32'hA5);
`endif
        chk("a5_rempty_after", rempty, 1);

        // ---- Underflow from empty ----
        chk("udf_before", runderflow, 0);
        rinc = 1'b1;
        @(posedge rclk); #1;
        rinc = 1'b0;
        chk("udf_flag", runderflow, 1);
        chk("udf_rvalid", rvalid, 0);
        chk("udf_rlevel", rlevel, 0);
        chk("udf_rempty", rempty, 1);

        // ---- Table-driven fill plus overflow attempt ----
        do_reset();
        for (int i = 0; i < 17; i++) begin
            winc  = tv[i].winc;
            wdata = tv[i].wdata;
            @(posedge wclk); #1;
            winc = 1'b0;
            chk($sformatf("fill%0d_wfull", i), wfull, tv[i].exp_wfull);
            chk($sformatf("fill%0d_wafull", i), wafull, tv[i].exp_wafull);
            chk($sformatf("fill%0d_wlevel", i), wlevel, tv[i].exp_wlevel);
            chk($sformatf("fill%0d_wovf", i), woverflow, tv[i].exp_wovf);
        end

        // ---- Drain all 16: sequence 1..16, 0xDEAD never appears ----
        n = 0;
        while (rempty && n < 64) begin @(posedge rclk); #1; n++; end
        repeat (4) @(posedge rclk);
        #1;
        chk("full_rlevel", rlevel, DEPTH);
        chk("full_raempty", raempty, 0);
        for (int i = 0; i < 16; i++) begin
            rd_check(DW'(i + 1), $sformatf("drain%0d", i));
        end
        chk("drain_rempty", rempty, 1);
        chk("drain_rlevel", rlevel, 0);
        chk("drain_raempty", raempty, 1);
        repeat (10) @(posedge wclk);
        #1;
        chk("drain_wfull", wfull, 0);
        chk("drain_wafull", wafull, 0);
        chk("drain_wlevel", wlevel, 0);
        chk("drain_wovf_sticky", woverflow, 1);

        // ---- Randomized dual-clock scoreboard run ----
        do_reset();
        wr_cnt = 0; rd_cnt = 0;
        q.delete();
        fork
            writer_proc();
            reader_proc();
        join
        repeat (8) @(posedge rclk);
        #1;
        chk("rnd_end_rempty", rempty, 1);
        chk("rnd_end_rlevel", rlevel, 0);
        repeat (8) @(posedge wclk);
        #1;
        chk("rnd_end_wlevel", wlevel, 0);
        chk("rnd_end_wfull", wfull, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
